// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew hazard unit for a 5-stage MIPS pipeline.
// Keeps a shadow copy of the destination register and Tnew for E, M and W
// (plus the source registers of E). From these it drives the D-stage stall,
// the E-stage bubble and the forwarding selects for D and E, and it adds an
// interlock for the multi-cycle mult/div unit.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   rs_D, rt_D              D-stage source registers
//   tuse_rs_D, tuse_rt_D    cycles until the source is consumed; all-ones = unused
//   waddr_D, tnew_D         D-stage destination (0 = none) and result latency
//   md_start_D, md_div_D    D instr starts a mult (0) / div (1)
//   md_use_D                D instr needs HI/LO or the MD unit
//   clear_E                 flush E at the next edge
//   stall                   hold PC and F/D (combinational)
//   bubble_E                load a nop into D/E (combinational)
//   fwd_rs_D, fwd_rt_D      00 RF, 01 E, 10 M, 11 W (combinational)
//   fwd_rs_E, fwd_rt_E      00 D/E value, 01 M, 10 W (combinational)
//   md_busy                 MD unit still counting (registered)
module hazard_scoreboard #(
  parameter int unsigned AW      = 5,
  parameter int unsigned TW      = 2,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic [AW-1:0] waddr_D,
  input  logic [TW-1:0] tnew_D,
  input  logic          md_start_D,
  input  logic          md_div_D,
  input  logic          md_use_D,
  input  logic          clear_E,
  output logic          stall,
  output logic          bubble_E,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic [1:0]    fwd_rs_E,
  output logic [1:0]    fwd_rt_E,
  output logic          md_busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  // Shadow pipeline
  logic [AW-1:0] waddrE, waddrM, waddrW;
  logic [TW-1:0] tnewE, tnewM, tnewW;
  logic [AW-1:0] rsE, rtE;
  logic          mdE;

  // MD unit busy counter
  logic [CW-1:0] mdCnt, mdCntNext;
  logic          mdBusyQ;

  // Tnew counts down as an instruction moves on, never below zero
  function automatic logic [TW-1:0] decSat(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  // Youngest matching producer in E/M decides whether the consumer must wait
  function automatic logic needStall(
    input logic [AW-1:0] r,  input logic [TW-1:0] tuse,
    input logic [AW-1:0] wE, input logic [TW-1:0] tE,
    input logic [AW-1:0] wM, input logic [TW-1:0] tM
  );
    logic res;
    res = 1'b0;
    if (r != '0 && tuse != TUSE_NONE) begin
      if (wE == r)      res = (tE > tuse);
      else if (wM == r) res = (tM > tuse);
    end
    return res;
  endfunction

  // Youngest match wins; a non-live youngest match hides older ones (stall covers it)
  function automatic logic [1:0] selFwdD(
    input logic [AW-1:0] r,
    input logic [AW-1:0] wE, input logic [TW-1:0] tE,
    input logic [AW-1:0] wM, input logic [TW-1:0] tM,
    input logic [AW-1:0] wW, input logic [TW-1:0] tW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (r != '0) begin
      if (wE == r)      sel = (tE == '0) ? 2'b01 : 2'b00;
      else if (wM == r) sel = (tM == '0) ? 2'b10 : 2'b00;
      else if (wW == r) sel = (tW == '0) ? 2'b11 : 2'b00;
    end
    return sel;
  endfunction

  // E-stage operands take the nearest live producer in M, then W
  function automatic logic [1:0] selFwdE(
    input logic [AW-1:0] r,
    input logic [AW-1:0] wM, input logic [TW-1:0] tM,
    input logic [AW-1:0] wW, input logic [TW-1:0] tW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (r != '0) begin
      if (wM == r && tM == '0)      sel = 2'b01;
      else if (wW == r && tW == '0) sel = 2'b10;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding select
  always_comb begin
    stall    = 1'b0;
    bubble_E = 1'b0;
    fwd_rs_D = 2'b00;
    fwd_rt_D = 2'b00;
    fwd_rs_E = 2'b00;
    fwd_rt_E = 2'b00;

    stall = needStall(rs_D, tuse_rs_D, waddrE, tnewE, waddrM, tnewM)
          | needStall(rt_D, tuse_rt_D, waddrE, tnewE, waddrM, tnewM)
          | (md_use_D & (mdBusyQ | mdE));
    bubble_E = stall | clear_E;

    fwd_rs_D = selFwdD(rs_D, waddrE, tnewE, waddrM, tnewM, waddrW, tnewW);
    fwd_rt_D = selFwdD(rt_D, waddrE, tnewE, waddrM, tnewM, waddrW, tnewW);
    fwd_rs_E = selFwdE(rsE, waddrM, tnewM, waddrW, tnewW);
    fwd_rt_E = selFwdE(rtE, waddrM, tnewM, waddrW, tnewW);
  end

  // MD counter: a mult/div that actually reaches E reloads it, otherwise it drains
  always_comb begin
    mdCntNext = (mdCnt == '0) ? mdCnt : mdCnt - CW'(1);
    if (md_start_D && !bubble_E) begin
      mdCntNext = md_div_D ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end
  end

  // Shadow pipeline shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddrE  <= '0;
      tnewE   <= '0;
      rsE     <= '0;
      rtE     <= '0;
      mdE     <= 1'b0;
      waddrM  <= '0;
      tnewM   <= '0;
      waddrW  <= '0;
      tnewW   <= '0;
      mdCnt   <= '0;
      mdBusyQ <= 1'b0;
    end else begin
      waddrM <= waddrE;
      tnewM  <= decSat(tnewE);
      waddrW <= waddrM;
      tnewW  <= decSat(tnewM);
      if (bubble_E) begin
        waddrE <= '0;
        tnewE  <= '0;
        rsE    <= '0;
        rtE    <= '0;
        mdE    <= 1'b0;
      end else begin
        waddrE <= waddr_D;
        tnewE  <= tnew_D;
        rsE    <= rs_D;
        rtE    <= rt_D;
        mdE    <= md_start_D;
      end
      mdCnt   <= mdCntNext;
      mdBusyQ <= (mdCntNext != '0);
    end
  end

  assign md_busy = mdBusyQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios plus randomized instruction
// streams, checked against an age-based reference model of in-flight instructions.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, waddr_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       md_start_D, md_div_D, md_use_D, clear_E;
  logic       stall, bubble_E, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .waddr_D(waddr_D), .tnew_D(tnew_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .clear_E(clear_E),
    .stall(stall), .bubble_E(bubble_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuseRs;
    logic [1:0] tuseRt;
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic       mdStart;
    logic       mdDiv;
    logic       mdUse;
  } instr_t;

  // One in-flight instruction as the model sees it; index in pipe = age after entering E
  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md;
  } ent_t;

  ent_t pipe [3];
  int   cyc;
  int   mdDone;

  function automatic instr_t mk(input logic [4:0] rs, input logic [1:0] tuRs,
                                input logic [4:0] rt, input logic [1:0] tuRt,
                                input logic [4:0] wa, input logic [1:0] tn);
    instr_t x;
    x = '0;
    x.rs = rs; x.tuseRs = tuRs; x.rt = rt; x.tuseRt = tuRt;
    x.waddr = wa; x.tnew = tn;
    return x;
  endfunction

  function automatic instr_t nop();
    return mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
  endfunction

  task automatic apply(input instr_t x, input logic clr);
    rs_D = x.rs; rt_D = x.rt; tuse_rs_D = x.tuseRs; tuse_rt_D = x.tuseRt;
    waddr_D = x.waddr; tnew_D = x.tnew;
    md_start_D = x.mdStart; md_div_D = x.mdDiv; md_use_D = x.mdUse;
    clear_E = clr;
  endtask

  function automatic void resetModel();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    cyc = 0;
    mdDone = 0;
  endfunction

  // Cycles still needed before the instruction of this age has its result
  function automatic int remT(input int age);
    return (int'(pipe[age].tnew) > age) ? int'(pipe[age].tnew) - age : 0;
  endfunction

  function automatic logic mStallR(input logic [4:0] r, input logic [1:0] tu);
    if (r == 5'd0 || tu == 2'd3) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (pipe[i].waddr == r) return remT(i) > int'(tu);
    return 1'b0;
  endfunction

  function automatic logic mBusy();
    return cyc < mdDone;
  endfunction

  function automatic logic mStall();
    return mStallR(rs_D, tuse_rs_D) | mStallR(rt_D, tuse_rt_D) |
           (md_use_D & (mBusy() | pipe[0].md));
  endfunction

  function automatic logic [1:0] mFwdD(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    for (int i = 0; i < 3; i++)
      if (pipe[i].waddr == r) return (remT(i) == 0) ? 2'(i + 1) : 2'b00;
    return 2'b00;
  endfunction

  function automatic logic [1:0] mFwdE(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (pipe[1].waddr == r && remT(1) == 0) return 2'b01;
    if (pipe[2].waddr == r && remT(2) == 0) return 2'b10;
    return 2'b00;
  endfunction

  // Advance one clock; the model moves every instruction one stage older
  task automatic tick();
    logic bub;
    ent_t ne;
    bub = mStall() | clear_E;
    ne = '0;
    if (!bub) begin
      ne = '{waddr: waddr_D, tnew: tnew_D, rs: rs_D, rt: rt_D, md: md_start_D};
      if (md_start_D) mdDone = cyc + 1 + (md_div_D ? 10 : 5);
    end
    @(posedge clk);
    cyc++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = ne;
    #1;
  endtask

  task automatic drain();
    apply(nop(), 1'b0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resetModel();
    apply(nop(), 1'b0);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
    checks++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin errors++;
      $display("FAIL reset_fwd: got %h want 00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bubble_E !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", bubble_E); end
    tick();
  endtask

  task automatic test_alu_b2b();
    apply(mk(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1), 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd3, 2'd1, 5'd2, 2'd1, 5'd9, 2'd1), 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_b2b_stall: got %b want 0", stall); end
    tick();
    apply(nop(), 1'b0);
    @(negedge clk);
    checks++; if (fwd_rs_E !== 2'b01) begin errors++; $display("FAIL alu_b2b_fwd_rs_E: got %b want 01", fwd_rs_E); end
    drain();
  endtask

  task automatic test_load_use();
    apply(mk(5'd1, 2'd1, 5'd0, 2'd3, 5'd4, 2'd2), 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd4, 2'd1, 5'd0, 2'd3, 5'd8, 2'd1), 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall1: got %b want 1", stall); end
    checks++; if (bubble_E !== 1'b1) begin errors++; $display("FAIL load_use_bubble: got %b want 1", bubble_E); end
    tick(); @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_stall2: got %b want 0", stall); end
    tick();
    apply(nop(), 1'b0);
    @(negedge clk);
    checks++; if (fwd_rs_E !== 2'b10) begin errors++; $display("FAIL load_use_fwd_rs_E: got %b want 10", fwd_rs_E); end
    drain();
  endtask

  task automatic test_load_branch();
    apply(mk(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2), 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0), 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_branch_stall%0d: got %b want 1", i, stall); end
      tick();
    end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_branch_release: got %b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'b11) begin errors++; $display("FAIL load_branch_fwd_rs_D: got %b want 11", fwd_rs_D); end
    drain();
  endtask

  task automatic test_jal_jr();
    apply(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0), 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0), 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jal_jr_stall: got %b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'b01) begin errors++; $display("FAIL jal_jr_fwd_rs_D: got %b want 01", fwd_rs_D); end
    drain();
  endtask

  task automatic test_md();
    instr_t op, mflo;
    int n;
    for (int k = 0; k < 2; k++) begin
      op = nop(); op.mdStart = 1'b1; op.mdDiv = (k == 0); op.mdUse = 1'b1;
      mflo = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1); mflo.mdUse = 1'b1;
      apply(op, 1'b0);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md%0d_start_stall: got %b want 0", k, stall); end
      tick();
      apply(mflo, 1'b0);
      @(negedge clk);
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md%0d_busy: got %b want 1", k, md_busy); end
      n = 0;
      while (stall === 1'b1 && n < 40) begin
        n++;
        tick();
        @(negedge clk);
      end
      checks++; if (n != ((k == 0) ? 10 : 5)) begin errors++;
        $display("FAIL md%0d_stall_cycles: got %0d want %0d", k, n, (k == 0) ? 10 : 5); end
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md%0d_idle: got %b want 0", k, md_busy); end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    instr_t op;
    op = nop(); op.mdStart = 1'b1; op.mdDiv = 1'b1; op.mdUse = 1'b1;
    apply(op, 1'b1);
    @(negedge clk);
    checks++; if (bubble_E !== 1'b1) begin errors++; $display("FAIL flush_bubble: got %b want 1", bubble_E); end
    tick();
    apply(nop(), 1'b0);
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_md_busy: got %b want 0", md_busy); end
    tick();
    apply(mk(5'd1, 2'd1, 5'd0, 2'd3, 5'd6, 2'd2), 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd6, 2'd1, 5'd0, 2'd3, 5'd7, 2'd1), 1'b1);
    @(negedge clk);
    checks++; if ({stall, bubble_E} !== 2'b11) begin errors++; $display("FAIL flush_stall_clear: got %b want 11", {stall, bubble_E}); end
    tick();
    clear_E = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_one_bubble: got %b want 0", stall); end
    drain();
  endtask

  task automatic test_zero_and_reset();
    instr_t op, cons;
    apply(mk(5'd1, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2), 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0), 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
    checks++; if ({fwd_rs_D, fwd_rt_D} !== 4'h0) begin errors++; $display("FAIL zero_fwd_D: got %h want 0", {fwd_rs_D, fwd_rt_D}); end
    tick(); drain();
    op = nop(); op.mdStart = 1'b1; op.mdDiv = 1'b1; op.mdUse = 1'b1;
    apply(op, 1'b0);
    @(negedge clk); tick();
    apply(mk(5'd1, 2'd1, 5'd2, 2'd1, 5'd7, 2'd0), 1'b0);
    @(negedge clk); tick();
    cons = mk(5'd7, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0); cons.mdUse = 1'b1;
    apply(cons, 1'b0);
    @(negedge clk);
    checks++; if ({stall, md_busy, fwd_rs_D, fwd_rt_D} !== 6'b110101) begin errors++;
      $display("FAIL pre_reset: got %b want 110101", {stall, md_busy, fwd_rs_D, fwd_rt_D}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({stall, bubble_E, md_busy} !== 3'b000) begin errors++;
      $display("FAIL mid_reset_ctrl: got %b want 000", {stall, bubble_E, md_busy}); end
    checks++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin errors++;
      $display("FAIL mid_reset_fwd: got %h want 00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}); end
    resetModel();
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(nop(), 1'b0);
    drain();
  endtask

  task automatic test_random();
    instr_t cur;
    logic clr, hold;
    int r;
    hold = 1'b0;
    cur = nop();
    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        rst_n = 1'b0;
        resetModel();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      if (!hold) begin
        cur = mk(5'($urandom_range(3)), 2'($urandom_range(3)), 5'($urandom_range(3)),
                 2'($urandom_range(3)), 5'($urandom_range(3)), 2'($urandom_range(3)));
        r = $urandom_range(19);
        if (r == 0) begin cur.mdStart = 1'b1; cur.mdDiv = 1'($urandom_range(1)); cur.mdUse = 1'b1; end
        else if (r < 3) cur.mdUse = 1'b1;
      end
      clr = ($urandom_range(7) == 0);
      apply(cur, clr);
      @(negedge clk);
      checks++; if (stall !== mStall()) begin errors++; $display("FAIL rnd_stall @%0d: got %b want %b", it, stall, mStall()); end
      checks++; if (bubble_E !== (mStall() | clr)) begin errors++; $display("FAIL rnd_bubble @%0d: got %b want %b", it, bubble_E, mStall() | clr); end
      checks++; if (fwd_rs_D !== mFwdD(rs_D)) begin errors++; $display("FAIL rnd_fwd_rs_D @%0d: got %b want %b", it, fwd_rs_D, mFwdD(rs_D)); end
      checks++; if (fwd_rt_D !== mFwdD(rt_D)) begin errors++; $display("FAIL rnd_fwd_rt_D @%0d: got %b want %b", it, fwd_rt_D, mFwdD(rt_D)); end
      checks++; if (fwd_rs_E !== mFwdE(pipe[0].rs)) begin errors++; $display("FAIL rnd_fwd_rs_E @%0d: got %b want %b", it, fwd_rs_E, mFwdE(pipe[0].rs)); end
      checks++; if (fwd_rt_E !== mFwdE(pipe[0].rt)) begin errors++; $display("FAIL rnd_fwd_rt_E @%0d: got %b want %b", it, fwd_rt_E, mFwdE(pipe[0].rt)); end
      checks++; if (md_busy !== mBusy()) begin errors++; $display("FAIL rnd_md_busy @%0d: got %b want %b", it, md_busy, mBusy()); end
      hold = mStall();
      tick();
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    resetModel();
    apply(nop(), 1'b0);
    test_reset();
    test_alu_b2b();
    test_load_use();
    test_load_branch();
    test_jal_jr();
    test_md();
    test_flush();
    test_zero_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
